mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between fetch and data requests
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_order,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_data,
    output logic              i_done,
    input  logic              d_order,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t            state;
    logic              i_pend;
    logic              d_pend;
    logic              d_we_q;
    logic              last_d;
    logic [ADDR_W-1:0] i_addr_q;
    logic [ADDR_W-1:0] d_addr_q;
    logic [DATA_W-1:0] d_wdata_q;
    logic              grant_d;

    // last_d records the winner of the most recent contended arbitration only
    assign grant_d = d_pend && (!i_pend || !last_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            i_pend    <= 1'b0;
            d_pend    <= 1'b0;
            d_we_q    <= 1'b0;
            last_d    <= 1'b0;
            i_addr_q  <= '0;
            d_addr_q  <= '0;
            d_wdata_q <= '0;
            m_req     <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            i_data    <= '0;
            d_rdata   <= '0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            if (i_order && !i_pend) begin
                i_pend   <= 1'b1;
                i_addr_q <= i_addr;
            end
            if (d_order && !d_pend) begin
                d_pend    <= 1'b1;
                d_we_q    <= d_we;
                d_addr_q  <= d_addr;
                d_wdata_q <= d_wdata;
            end
            case (state)
                IDLE: begin
                    if (i_pend || d_pend) begin
                        state   <= grant_d ? BUSY_D : BUSY_I;
                        m_req   <= 1'b1;
                        m_addr  <= grant_d ? d_addr_q : i_addr_q;
                        m_we    <= grant_d & d_we_q;
                        m_wdata <= grant_d ? d_wdata_q : '0;
                        if (i_pend && d_pend)
                            last_d <= grant_d;
                    end
                end
                BUSY_I: begin
                    if (m_ack) begin
                        i_data <= m_rdata;
                        i_done <= 1'b1;
                        i_pend <= 1'b0;
                        m_req  <= 1'b0;
                        state  <= IDLE;
                    end
                end
                BUSY_D: begin
                    if (m_ack) begin
                        if (!d_we_q)
                            d_rdata <= m_rdata;
                        d_done <= 1'b1;
                        d_pend <= 1'b0;
                        m_req  <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a transaction model
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_order = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_data;
    logic        i_done;
    logic        d_order = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;
    logic        m_ack = 1'b0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_order(i_order), .i_addr(i_addr), .i_data(i_data), .i_done(i_done),
        .d_order(d_order), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: pending slots, which port owns the memory (0 none, 1 fetch, 2 data), expected outputs
    logic        s_i, s_d, s_dwe, last_d;
    logic [31:0] s_ia, s_da, s_dwd;
    int          owner;
    logic        e_req, e_we, e_idone, e_ddone;
    logic [31:0] e_addr, e_wdata, e_idata, e_drdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        s_i = 0; s_d = 0; s_dwe = 0; last_d = 0;
        s_ia = '0; s_da = '0; s_dwd = '0; owner = 0;
        e_req = 0; e_we = 0; e_idone = 0; e_ddone = 0;
        e_addr = '0; e_wdata = '0; e_idata = '0; e_drdata = '0;
    endtask

    task automatic check_outputs();
        chk("m_req", 32'(m_req), 32'(e_req));
        if (e_req) begin
            chk("m_addr", m_addr, e_addr);
            chk("m_we", 32'(m_we), 32'(e_we));
            if (e_we) chk("m_wdata", m_wdata, e_wdata);
        end
        chk("i_done", 32'(i_done), 32'(e_idone));
        chk("d_done", 32'(d_done), 32'(e_ddone));
        chk("i_data", i_data, e_idata);
        chk("d_rdata", d_rdata, e_drdata);
    endtask

    task automatic model_edge(input logic io, input logic [31:0] ia, input logic dor,
                              input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
                              input logic ack, input logic [31:0] rd);
        logic oi, od, gd;
        oi = s_i;
        od = s_d;
        e_idone = 0;
        e_ddone = 0;
        if (owner != 0) begin
            if (ack) begin
                if (owner == 1) begin
                    e_idata = rd; e_idone = 1; s_i = 0;
                end else begin
                    if (!s_dwe) e_drdata = rd;
                    e_ddone = 1; s_d = 0;
                end
                e_req = 0;
                owner = 0;
            end
        end else if (oi || od) begin
            gd = od && (!oi || !last_d);
            if (oi && od) last_d = gd;
            owner  = gd ? 2 : 1;
            e_req  = 1;
            e_addr = gd ? s_da : s_ia;
            e_we   = gd && s_dwe;
            e_wdata = s_dwd;
        end
        if (io && !oi) begin s_i = 1; s_ia = ia; end
        if (dor && !od) begin s_d = 1; s_dwe = dwe; s_da = da; s_dwd = dwd; end
    endtask

    task automatic step(input logic io, input logic [31:0] ia, input logic dor, input logic dwe,
                        input logic [31:0] da, input logic [31:0] dwd,
                        input logic ack, input logic [31:0] rd);
        @(negedge clk);
        i_order = io; i_addr = ia; d_order = dor; d_we = dwe; d_addr = da; d_wdata = dwd;
        m_ack = ack; m_rdata = rd;
        check_outputs();
        @(posedge clk);
        model_edge(io, ia, dor, dwe, da, dwd, ack, rd);
    endtask

    task automatic idle(input int n, input logic ack, input logic [31:0] rd);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, ack, rd);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_order = 0; d_order = 0; m_ack = 0;
        rst = 1;
        #1;
        chk("rst_m_req", 32'(m_req), 0);
        chk("rst_d_done", 32'(d_done), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        logic io, dor, dwe, ack;
        model_reset();
        do_reset();
        chk("rst_i_data", i_data, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_m_we", 32'(m_we), 0);
        chk("rst_i_done", 32'(i_done), 0);

        // single fetch
        step(1, 32'h40, 0, 0, 0, 0, 0, 0);
        idle(1, 0, 0);
        #1;
        chk("fetch_m_req", 32'(m_req), 1);
        chk("fetch_m_addr", m_addr, 32'h40);
        chk("fetch_m_we", 32'(m_we), 0);
        idle(1, 0, 0);
        idle(1, 1, 32'h00500093);
        #1;
        chk("fetch_i_done", 32'(i_done), 1);
        chk("fetch_i_data", i_data, 32'h00500093);
        chk("fetch_m_req_off", 32'(m_req), 0);
        idle(1, 0, 0);

        // tie: data first, then fetch; the next tie goes to fetch
        step(1, 32'h10, 1, 0, 32'h200, 0, 0, 0);
        idle(1, 0, 0);
        #1;
        chk("tie1_m_addr", m_addr, 32'h200);
        idle(1, 1, 32'h1111);
        #1;
        chk("tie1_d_done", 32'(d_done), 1);
        chk("tie1_i_done", 32'(i_done), 0);
        chk("tie1_d_rdata", d_rdata, 32'h1111);
        idle(1, 0, 0);
        #1;
        chk("tie1_second_addr", m_addr, 32'h10);
        idle(1, 1, 32'h2222);
        #1;
        chk("tie1_i_data", i_data, 32'h2222);
        idle(1, 0, 0);
        step(1, 32'h14, 1, 0, 32'h204, 0, 0, 0);
        idle(1, 0, 0);
        #1;
        chk("tie2_m_addr", m_addr, 32'h14);
        idle(1, 1, 32'h2323);
        idle(1, 0, 0);
        idle(1, 1, 32'h3333);
        idle(1, 0, 0);

        // store leaves d_rdata alone
        step(0, 0, 1, 1, 32'h300, 32'hDEADBEEF, 0, 0);
        idle(1, 0, 0);
        #1;
        chk("st_m_we", 32'(m_we), 1);
        chk("st_m_wdata", m_wdata, 32'hDEADBEEF);
        chk("st_m_addr", m_addr, 32'h300);
        idle(1, 1, 32'h5555);
        #1;
        chk("st_d_done", 32'(d_done), 1);
        chk("st_d_rdata", d_rdata, 32'h3333);

        // duplicate fetch dropped
        step(1, 32'h40, 0, 0, 0, 0, 0, 0);
        step(1, 32'h80, 0, 0, 0, 0, 0, 0);
        #1;
        chk("dup_m_addr", m_addr, 32'h40);
        idle(1, 1, 32'h7777);
        idle(4, 0, 0);
        #1;
        chk("dup_no_reissue", 32'(m_req), 0);

        // reset while the data access is on the bus
        step(0, 0, 1, 0, 32'h400, 0, 0, 0);
        idle(1, 0, 0);
        #1;
        chk("mid_m_req_before", 32'(m_req), 1);
        do_reset();
        idle(3, 0, 0);
        step(0, 0, 1, 0, 32'h404, 0, 0, 0);
        idle(1, 0, 0);
        idle(1, 1, 32'h8888);
        #1;
        chk("post_rst_d_done", 32'(d_done), 1);
        chk("post_rst_d_rdata", d_rdata, 32'h8888);
        idle(1, 0, 0);

        // ack with no request outstanding
        idle(1, 1, 32'hFFFF);
        #1;
        chk("spur_i_done", 32'(i_done), 0);
        chk("spur_d_done", 32'(d_done), 0);
        chk("spur_d_rdata", d_rdata, 32'h8888);

        // randomized traffic, including stray acks while idle
        for (int n = 0; n < 600; n++) begin
            io  = ($urandom_range(0, 3) == 0);
            dor = ($urandom_range(0, 3) == 0);
            dwe = $urandom_range(0, 1) == 1;
            ack = e_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            step(io, $urandom, dor, dwe, $urandom, $urandom, ack, $urandom);
        end
        idle(1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
